ecc_43_rd_stage: RTL and testbench

//  FIFO read-path ECC stage, sitting directly downstream of the FIFO memory read port.

---
 rtl/ecc_43_rd_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ecc_43_rd_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_43_rd_stage.sv
// FIFO read-path ECC stage: SEC-DED decode of each 43+7 bit memory word,
// a 2-entry skid buffer toward the consumer, error counters, first-error
// syndrome capture and a DED interrupt pulse.
//
// Code: bits [5:0] of the parity are truncated Hamming(63,57) check bits,
// with data bit i sitting at the i-th non-power-of-two position (3,5,6,7,9..).
// Bit 6 is the overall parity of data plus check bits, which makes every
// data column odd weight (>= 3) and every parity column weight 1.

module ecc_43_top #(
  parameter int DATA_W = 43,
  parameter int PAR_W  = 7
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [PAR_W-1:0]  i_par,
  output logic [DATA_W-1:0] o_data,
  output logic [PAR_W-1:0]  o_syn,
  output logic              o_sbit,
  output logic              o_dbit
);

  localparam int HAM_W = PAR_W - 1;

  // Hamming position of each data bit (skips the power-of-two check slots).
  function automatic logic [DATA_W-1:0][HAM_W-1:0] f_pos();
    logic [DATA_W-1:0][HAM_W-1:0] pos;
    int unsigned                  j;
    pos = '0;
    j   = 0;
    for (int unsigned p = 1; p < (1 << HAM_W); p++) begin
      if (((p & (p - 1)) != 0) && (j < DATA_W)) begin
        pos[j] = HAM_W'(p);
        j++;
      end
    end
    return pos;
  endfunction

  localparam logic [DATA_W-1:0][HAM_W-1:0] POS = f_pos();

  logic [PAR_W-1:0] w_enc;
  logic [PAR_W-1:0] w_syn;
  logic             w_hit;
  logic             w_one;

  // Re-encode parity from the received data.
  always_comb begin
    w_enc = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      for (int unsigned k = 0; k < HAM_W; k++) begin
        w_enc[k] = w_enc[k] ^ (i_data[i] & POS[i][k]);
      end
    end
    w_enc[PAR_W-1] = (^i_data) ^ (^w_enc[HAM_W-1:0]);
  end

  assign w_syn = i_par ^ w_enc;
  assign o_syn = w_syn;

  // Match the syndrome against each data column and flip the hit bit.
  always_comb begin
    o_data = i_data;
    w_hit  = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (w_syn == {~^POS[i], POS[i]}) begin
        o_data[i] = ~i_data[i];
        w_hit     = 1'b1;
      end
    end
  end

  assign w_one  = ($countones(w_syn) == 1);
  assign o_sbit = w_one | w_hit;
  assign o_dbit = (w_syn != '0) & ~(w_one | w_hit);

endmodule

module ecc_43_rd_stage #(
  parameter int DATA_W = 43,
  parameter int PAR_W  = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_vld_i,
  output logic              rd_rdy_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [PAR_W-1:0]  rd_par_i,
  input  logic              ecc_bypass_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sbit_o,
  output logic              out_dbit_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  sbit_cnt_o,
  output logic [CNT_W-1:0]  dbit_cnt_o,
  output logic [PAR_W-1:0]  err_syn_o,
  output logic              err_syn_vld_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t              r_state;
  logic                r_rdy;
  logic                r_vld;
  logic [DATA_W-1:0]   r_main_data;
  logic                r_main_sbit;
  logic                r_main_dbit;
  logic [DATA_W-1:0]   r_skid_data;
  logic                r_skid_sbit;
  logic                r_skid_dbit;
  logic [CNT_W-1:0]    r_sbit_cnt;
  logic [CNT_W-1:0]    r_dbit_cnt;
  logic [PAR_W-1:0]    r_syn;
  logic                r_syn_vld;
  logic                r_irq;

  logic [DATA_W-1:0]   w_dec_data;
  logic [PAR_W-1:0]    w_dec_syn;
  logic                w_dec_sbit;
  logic                w_dec_dbit;
  logic [DATA_W-1:0]   w_data;
  logic                w_sbit;
  logic                w_dbit;
  logic                w_accept;
  logic                w_pop;
  logic                w_sbit_ev;
  logic                w_dbit_ev;
  logic [CNT_W-1:0]    w_sbit_base;
  logic [CNT_W-1:0]    w_dbit_base;
  logic [CNT_W-1:0]    w_sbit_nxt;
  logic [CNT_W-1:0]    w_dbit_nxt;
  logic [PAR_W-1:0]    w_syn_base;
  logic                w_syn_vld_base;

  ecc_43_top #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W)
  ) u_ecc (
    .i_data (rd_data_i),
    .i_par  (rd_par_i),
    .o_data (w_dec_data),
    .o_syn  (w_dec_syn),
    .o_sbit (w_dec_sbit),
    .o_dbit (w_dec_dbit)
  );

  assign w_data    = ecc_bypass_i ? rd_data_i : w_dec_data;
  assign w_sbit    = ~ecc_bypass_i & w_dec_sbit;
  assign w_dbit    = ~ecc_bypass_i & w_dec_dbit;
  assign w_accept  = rd_vld_i & r_rdy;
  assign w_pop     = r_vld & out_rdy_i;
  assign w_sbit_ev = w_accept & w_sbit;
  assign w_dbit_ev = w_accept & w_dbit;

  // Skid buffer FSM; ready and valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_rdy       <= 1'b1;
      r_vld       <= 1'b0;
      r_main_data <= '0;
      r_main_sbit <= 1'b0;
      r_main_dbit <= 1'b0;
      r_skid_data <= '0;
      r_skid_sbit <= 1'b0;
      r_skid_dbit <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_data <= w_data;
            r_main_sbit <= w_sbit;
            r_main_dbit <= w_dbit;
            r_vld       <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({w_accept, w_pop})
            2'b10: begin
              r_skid_data <= w_data;
              r_skid_sbit <= w_sbit;
              r_skid_dbit <= w_dbit;
              r_rdy       <= 1'b0;
              r_state     <= ST_TWO;
            end
            2'b11: begin
              r_main_data <= w_data;
              r_main_sbit <= w_sbit;
              r_main_dbit <= w_dbit;
            end
            2'b01: begin
              r_vld   <= 1'b0;
              r_state <= ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (w_pop) begin
            r_main_data <= r_skid_data;
            r_main_sbit <= r_skid_sbit;
            r_main_dbit <= r_skid_dbit;
            r_rdy       <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        default: begin
          r_vld   <= 1'b0;
          r_rdy   <= 1'b1;
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  // Clear is applied before the event so clear+event leaves a count of 1
  // and lets the new error be captured.
  always_comb begin
    w_sbit_base    = cnt_clr_i ? '0 : r_sbit_cnt;
    w_dbit_base    = cnt_clr_i ? '0 : r_dbit_cnt;
    w_sbit_nxt     = (w_sbit_ev && (w_sbit_base != '1)) ? w_sbit_base + CNT_W'(1) : w_sbit_base;
    w_dbit_nxt     = (w_dbit_ev && (w_dbit_base != '1)) ? w_dbit_base + CNT_W'(1) : w_dbit_base;
    w_syn_base     = cnt_clr_i ? '0 : r_syn;
    w_syn_vld_base = ~cnt_clr_i & r_syn_vld;
  end

  // Saturating counters, first-error syndrome capture and DED pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbit_cnt <= '0;
      r_dbit_cnt <= '0;
      r_syn      <= '0;
      r_syn_vld  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_sbit_cnt <= w_sbit_nxt;
      r_dbit_cnt <= w_dbit_nxt;
      r_irq      <= w_dbit_ev;
      if ((w_sbit_ev | w_dbit_ev) && !w_syn_vld_base) begin
        r_syn     <= w_dec_syn;
        r_syn_vld <= 1'b1;
      end else begin
        r_syn     <= w_syn_base;
        r_syn_vld <= w_syn_vld_base;
      end
    end
  end

  assign rd_rdy_o      = r_rdy;
  assign out_vld_o     = r_vld;
  assign out_data_o    = r_main_data;
  assign out_sbit_o    = r_main_sbit;
  assign out_dbit_o    = r_main_dbit;
  assign sbit_cnt_o    = r_sbit_cnt;
  assign dbit_cnt_o    = r_dbit_cnt;
  assign err_syn_o     = r_syn;
  assign err_syn_vld_o = r_syn_vld;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_ecc_43_rd_stage.sv
// Bench for ecc_43_rd_stage: a queue-based reference model with trial-flip
// decoding, a per-cycle compare process, and directed scenarios with
// hand-computed expectations. A second instance uses CNT_W = 2 for saturation.

module tb_ecc_43_rd_stage;

  logic        clk;
  logic        rst_n;
  logic        rd_vld_i;
  logic [42:0] rd_data_i;
  logic [6:0]  rd_par_i;
  logic        ecc_bypass_i;
  logic        out_rdy_i;
  logic        cnt_clr_i;

  logic        rd_rdy_o, out_vld_o, out_sbit_o, out_dbit_o, err_syn_vld_o, irq_o;
  logic [42:0] out_data_o;
  logic [15:0] sbit_cnt_o, dbit_cnt_o;
  logic [6:0]  err_syn_o;

  logic        b_rd_rdy, b_out_vld, b_out_sbit, b_out_dbit, b_syn_vld, b_irq;
  logic [42:0] b_out_data;
  logic [1:0]  b_sbit_cnt, b_dbit_cnt;
  logic [6:0]  b_syn;

  ecc_43_rd_stage u_dut (
    .clk(clk), .rst_n(rst_n), .rd_vld_i(rd_vld_i), .rd_rdy_o(rd_rdy_o),
    .rd_data_i(rd_data_i), .rd_par_i(rd_par_i), .ecc_bypass_i(ecc_bypass_i),
    .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_data_o(out_data_o),
    .out_sbit_o(out_sbit_o), .out_dbit_o(out_dbit_o), .cnt_clr_i(cnt_clr_i),
    .sbit_cnt_o(sbit_cnt_o), .dbit_cnt_o(dbit_cnt_o), .err_syn_o(err_syn_o),
    .err_syn_vld_o(err_syn_vld_o), .irq_o(irq_o)
  );

  ecc_43_rd_stage #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rd_vld_i(rd_vld_i), .rd_rdy_o(b_rd_rdy),
    .rd_data_i(rd_data_i), .rd_par_i(rd_par_i), .ecc_bypass_i(ecc_bypass_i),
    .out_vld_o(b_out_vld), .out_rdy_i(out_rdy_i), .out_data_o(b_out_data),
    .out_sbit_o(b_out_sbit), .out_dbit_o(b_out_dbit), .cnt_clr_i(cnt_clr_i),
    .sbit_cnt_o(b_sbit_cnt), .dbit_cnt_o(b_dbit_cnt), .err_syn_o(b_syn),
    .err_syn_vld_o(b_syn_vld), .irq_o(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [42:0] d;
    logic        s;
    logic        b;
  } word_t;

  word_t      mq[$];
  int         m_sb, m_db, m_sb2, m_db2;
  logic [6:0] m_syn;
  logic       m_synv;
  logic       m_irq;
  int         checks;
  int         failures;
  logic       chk_en;
  logic       dut_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Codeword view: data bits placed at non-power-of-two positions 1..63,
  // check bit k = XOR of positions with bit k set, bit 6 = overall parity.
  function automatic logic [6:0] enc(input logic [42:0] d);
    logic [63:0] cw;
    logic [6:0]  p;
    int          j;
    cw = '0;
    p  = '0;
    j  = 0;
    for (int pos = 1; pos < 64; pos++) begin
      if (($countones(pos) != 1) && (j < 43)) begin
        cw[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++)
      for (int pos = 1; pos < 64; pos++)
        if (pos[k]) p[k] = p[k] ^ cw[pos];
    p[6] = (^d) ^ (^p[5:0]);
    return p;
  endfunction

  // Reference decode: try every single data-bit flip that reproduces the parity.
  task automatic model_dec(input logic [42:0] d, input logic [6:0] p, input logic byp,
                           output word_t w, output logic [6:0] s);
    logic [42:0] one;
    logic        found;
    s     = p ^ enc(d);
    w.d   = d;
    w.s   = 1'b0;
    w.b   = 1'b0;
    found = 1'b0;
    if (!byp && s != 7'd0) begin
      if ($countones(s) == 1) begin
        w.s = 1'b1;
      end else begin
        for (int i = 0; i < 43; i++) begin
          one = '0;
          one[i] = 1'b1;
          if (!found && enc(d ^ one) == p) begin
            found = 1'b1;
            w.d   = d ^ one;
          end
        end
        if (found) w.s = 1'b1;
        else       w.b = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sb = 0; m_db = 0; m_sb2 = 0; m_db2 = 0;
    m_syn = '0; m_synv = 1'b0; m_irq = 1'b0;
  endtask

  // One clock: drive inputs, advance the model across the edge.
  task automatic cycle(input logic vld, input logic [42:0] d, input logic [6:0] p,
                       input logic byp, input logic ordy, input logic clr, output logic acc);
    word_t      w;
    word_t      tmp;
    logic [6:0] s;
    logic       pop;
    rd_vld_i     = vld;
    rd_data_i    = d;
    rd_par_i     = p;
    ecc_bypass_i = byp;
    out_rdy_i    = ordy;
    cnt_clr_i    = clr;
    acc     = vld && (mq.size() < 2);
    pop     = (mq.size() > 0) && ordy;
    dut_acc = vld & rd_rdy_o;
    model_dec(d, p, byp, w, s);
    @(posedge clk);
    #1;
    if (pop) tmp = mq.pop_front();
    if (acc) mq.push_back(w);
    if (clr) begin
      m_sb = 0; m_db = 0; m_sb2 = 0; m_db2 = 0; m_synv = 1'b0; m_syn = '0;
    end
    if (acc && w.s) begin
      if (m_sb < 65535) m_sb++;
      if (m_sb2 < 3) m_sb2++;
    end
    if (acc && w.b) begin
      if (m_db < 65535) m_db++;
      if (m_db2 < 3) m_db2++;
    end
    if (acc && (w.s || w.b) && !m_synv) begin
      m_syn  = s;
      m_synv = 1'b1;
    end
    m_irq = acc && w.b;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, a);
  endtask

  // Send data d with data-bit and parity-bit flip masks applied.
  task automatic send(input logic [42:0] d, input logic [42:0] dm, input logic [6:0] pm,
                      input logic byp, input logic ordy, input logic clr, output logic acc);
    cycle(1'b1, d ^ dm, enc(d) ^ pm, byp, ordy, clr, acc);
  endtask

  function automatic logic [42:0] mkd(input int i);
    logic [63:0] t;
    t = 64'h0000_0123_4567_89ab * 64'(i + 1);
    t = t ^ (64'(i) << 33);
    return t[42:0];
  endfunction

  function automatic logic [42:0] bitm(input int b);
    logic [42:0] m;
    m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_rdy", 64'(rd_rdy_o), 64'(mq.size() < 2));
      check("out_vld", 64'(out_vld_o), 64'(mq.size() > 0));
      check("b_rd_rdy", 64'(b_rd_rdy), 64'(mq.size() < 2));
      check("b_out_vld", 64'(b_out_vld), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("out_data", 64'(out_data_o), 64'(mq[0].d));
        check("out_sbit", 64'(out_sbit_o), 64'(mq[0].s));
        check("out_dbit", 64'(out_dbit_o), 64'(mq[0].b));
        check("b_out_data", 64'(b_out_data), 64'(mq[0].d));
        check("b_out_flags", 64'({b_out_sbit, b_out_dbit}), 64'({mq[0].s, mq[0].b}));
      end
      check("sbit_cnt", 64'(sbit_cnt_o), 64'(m_sb));
      check("dbit_cnt", 64'(dbit_cnt_o), 64'(m_db));
      check("b_sbit_cnt", 64'(b_sbit_cnt), 64'(m_sb2));
      check("b_dbit_cnt", 64'(b_dbit_cnt), 64'(m_db2));
      check("err_syn", 64'(err_syn_o), 64'(m_syn));
      check("err_syn_vld", 64'(err_syn_vld_o), 64'(m_synv));
      check("b_err_syn", 64'({b_syn_vld, b_syn}), 64'({m_synv, m_syn}));
      check("irq", 64'(irq_o), 64'(m_irq));
      check("b_irq", 64'(b_irq), 64'(m_irq));
    end
  end

  initial begin
    logic        a;
    logic [42:0] d;
    int          idx;
    int          nacc;
    int          et;
    logic [42:0] dm;
    logic [6:0]  pm;

    checks = 0; failures = 0; chk_en = 1'b0;
    rd_vld_i = 1'b0; rd_data_i = '0; rd_par_i = '0; ecc_bypass_i = 1'b0;
    out_rdy_i = 1'b1; cnt_clr_i = 1'b0; dut_acc = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_vld", 64'(out_vld_o), 64'd0);
    check("reset_rd_rdy", 64'(rd_rdy_o), 64'd1);
    check("reset_counts", 64'({sbit_cnt_o, dbit_cnt_o, err_syn_vld_o, irq_o}), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Clean back-to-back stream.
    for (int i = 0; i < 8; i++) send(mkd(i), '0, '0, 1'b0, 1'b1, 1'b0, a);
    idle(2);

    // Single data-bit error on bit 17.
    d = mkd(20);
    send(d, bitm(17), '0, 1'b0, 1'b1, 1'b0, a);
    check("b17_data", 64'(out_data_o), 64'(d));
    check("b17_sbit", 64'(out_sbit_o), 64'd1);
    check("b17_cnt", 64'(sbit_cnt_o), 64'd1);
    check("b17_syn", 64'(err_syn_o), 64'(7'b1010111));
    check("b17_syn_vld", 64'(err_syn_vld_o), 64'd1);
    idle(1);

    // Double error on bits 0 and 1, then a later single error.
    d = mkd(21);
    send(d, bitm(0) | bitm(1), '0, 1'b0, 1'b1, 1'b0, a);
    check("ded_dbit", 64'(out_dbit_o), 64'd1);
    check("ded_cnt", 64'(dbit_cnt_o), 64'd1);
    check("ded_irq", 64'(irq_o), 64'd1);
    idle(1);
    check("ded_irq_off", 64'(irq_o), 64'd0);
    send(mkd(22), bitm(30), '0, 1'b0, 1'b1, 1'b0, a);
    check("syn_kept", 64'(err_syn_o), 64'(7'b1010111));

    // Back-to-back DED words, then parity-only errors.
    send(mkd(23), bitm(4) | bitm(40), '0, 1'b0, 1'b1, 1'b0, a);
    send(mkd(24), '0, 7'b0000011, 1'b0, 1'b1, 1'b0, a);
    check("irq_b2b", 64'(irq_o), 64'd1);
    send(mkd(25), '0, 7'b0001000, 1'b0, 1'b1, 1'b0, a);
    send(mkd(26), '0, 7'b1000000, 1'b0, 1'b1, 1'b0, a);
    idle(2);

    // Backpressure: consumer stalls for 5 cycles while the source stays valid.
    idx = 100; nacc = 0;
    for (int i = 0; i < 5; i++) begin
      send(mkd(idx), '0, '0, 1'b0, 1'b0, 1'b0, a);
      if (dut_acc) nacc++;
      if (a) idx++;
      if (i == 1) check("bp_rdy_low", 64'(rd_rdy_o), 64'd0);
    end
    check("bp_accepted", 64'(nacc), 64'd2);
    for (int i = 0; i < 4; i++) begin
      send(mkd(idx), '0, '0, 1'b0, 1'b1, 1'b0, a);
      if (a) idx++;
    end
    idle(3);

    // Mixed errors, gaps and intermittent backpressure; source holds until accepted.
    idx = 200;
    for (int i = 0; i < 24; i++) begin
      et = i % 4;
      dm = (et == 1) ? bitm((idx * 7) % 43) : (et == 2) ? (bitm(idx % 43) | bitm((idx + 9) % 43)) : '0;
      pm = (et == 3) ? 7'(1 << (idx % 7)) : 7'd0;
      if (i % 5 == 4) cycle(1'b0, '0, '0, 1'b0, (i % 3) != 1, 1'b0, a);
      else begin
        send(mkd(idx), dm, pm, 1'b0, (i % 3) != 1, 1'b0, a);
        if (a) idx++;
      end
    end
    idle(4);

    // Saturation on the 2-bit instance, then clear coinciding with an sbit beat.
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, a);
    for (int i = 0; i < 5; i++) send(mkd(300 + i), bitm(i * 5), '0, 1'b0, 1'b1, 1'b0, a);
    check("sat_b_cnt", 64'(b_sbit_cnt), 64'd3);
    check("sat_cnt", 64'(sbit_cnt_o), 64'd5);
    send(mkd(310), bitm(42), '0, 1'b0, 1'b1, 1'b1, a);
    check("clr_b_cnt", 64'(b_sbit_cnt), 64'd1);
    check("clr_cnt", 64'(sbit_cnt_o), 64'd1);
    check("clr_syn_vld", 64'(err_syn_vld_o), 64'd1);
    idle(1);

    // Bypass beat with bit 5 flipped passes through untouched.
    d = mkd(320);
    send(d, bitm(5), '0, 1'b1, 1'b1, 1'b0, a);
    check("byp_data", 64'(out_data_o), 64'(d ^ bitm(5)));
    check("byp_flags", 64'({out_sbit_o, out_dbit_o}), 64'd0);
    check("byp_cnt", 64'(sbit_cnt_o), 64'd1);
    idle(2);

    // Reset with two words buffered.
    send(mkd(330), '0, '0, 1'b0, 1'b0, 1'b0, a);
    send(mkd(331), bitm(9), '0, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, a);
    check("pre_rst_vld", 64'(out_vld_o), 64'd1);
    check("pre_rst_rdy", 64'(rd_rdy_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_vld", 64'(out_vld_o), 64'd0);
    check("rst_rdy", 64'(rd_rdy_o), 64'd1);
    check("rst_cnt", 64'({sbit_cnt_o, err_syn_vld_o}), 64'd0);
    model_reset();
    out_rdy_i = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(mkd(340 + i), '0, '0, 1'b0, 1'b1, 1'b0, a);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
